// File: rtl/exec_muldiv_unit.sv
// Multi-cycle multiply/divide companion to the ALU; owns the HI/LO pair.
// Define MULDIV_MADD_EN to enable MADD/MADDU (op 110/111); otherwise those ops are accepted as no-ops.
module exec_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   prod_q;
  logic [DATA_W-1:0]     opb_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic                  is_div_q, is_madd_q, neg_q, neg_rem_q, div_zero_q;

  logic                  accept, long_op, op_signed, last;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;

  logic [DATA_W:0]       add_sum, rem_sh;
  logic [DATA_W-1:0]     sub_w;
  logic                  ge;
  logic [2*DATA_W-1:0]   mul_next, div_next, step_d;
  logic [2*DATA_W-1:0]   mul_res, result;
  logic [DATA_W-1:0]     quo, rem;

  assign accept    = start && !flush && (state_q != RUN);
  assign long_op   = !op[2] || (MADD_EN && op[1]);
  assign op_signed = !op[0];
  assign last      = (state_q == RUN) && (cnt_q == CNT_W'(DATA_W - 1)) && !flush;

  assign a_neg = op_signed && rs_val[DATA_W-1];
  assign b_neg = op_signed && rt_val[DATA_W-1];
  assign a_mag = a_neg ? -rs_val : rs_val;
  assign b_mag = b_neg ? -rt_val : rt_val;

  // prod_q is shared: multiply keeps {partial, multiplier}, divide keeps {remainder, dividend/quotient}.
  assign add_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {add_sum, prod_q[DATA_W-1:1]};

  assign rem_sh   = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
  assign ge       = rem_sh >= {1'b0, opb_q};
  assign sub_w    = rem_sh[DATA_W-1:0] - opb_q;
  assign div_next = {ge ? sub_w : rem_sh[DATA_W-1:0], prod_q[DATA_W-2:0], ge};

  assign step_d   = is_div_q ? div_next : mul_next;

  always_comb begin
    mul_res = neg_q ? -step_d : step_d;
    quo     = neg_q ? -step_d[DATA_W-1:0] : step_d[DATA_W-1:0];
    rem     = neg_rem_q ? -step_d[2*DATA_W-1:DATA_W] : step_d[2*DATA_W-1:DATA_W];
    if (is_div_q)       result = {rem, quo};
    else if (is_madd_q) result = {hi_q, lo_q} + mul_res;
    else                result = mul_res;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept && long_op) state_d = RUN;
      end
      RUN: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      prod_q     <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      is_madd_q  <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= last && is_div_q && (opb_q == '0);
      if (accept) begin
        if (long_op) begin
          prod_q    <= {{DATA_W{1'b0}}, a_mag};
          opb_q     <= b_mag;
          cnt_q     <= '0;
          is_div_q  <= (op[2:1] == 2'b01);
          is_madd_q <= op[2];
          neg_q     <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
        end else if (op == 3'b100) begin
          hi_q <= rs_val;
        end else if (op == 3'b101) begin
          lo_q <= rs_val;
        end
      end else if (state_q == RUN) begin
        prod_q <= step_d;
        cnt_q  <= cnt_q + 1'b1;
        if (last && !(is_div_q && (opb_q == '0))) begin
          {hi_q, lo_q} <= result;
        end
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_exec_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic        flush = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [63:0] p_res = '0;
  logic        p_dz = 1'b0;
  bit          checking = 1'b0;

  exec_muldiv_unit #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .flush(flush),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] product(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    if (o[0] == 1'b0) return longint'($signed(a)) * longint'($signed(b));
    else              return 64'(a) * 64'(b);
  endfunction

  // Model: whole result computed at accept, then released after 32 cycles.
  always @(posedge clock) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_dz = 1'b0;
      checking = 1'b1;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_done = 1'b1;
            m_dz   = p_dz;
            if (!p_dz) {m_hi, m_lo} = p_res;
          end
        end
      end else if (start && !flush) begin
        int sa, sb;
        p_dz = 1'b0;
        case (op)
          3'd0, 3'd1: begin p_res = product(op, rs_val, rt_val); m_rem = 32; end
          3'd2: begin
            m_rem = 32;
            sa = rs_val; sb = rt_val;
            if (rt_val == 0) p_dz = 1'b1;
            else if (rs_val == 32'h80000000 && rt_val == 32'hFFFFFFFF)
              p_res = {32'h0, 32'h80000000};
            else p_res = {32'(sa % sb), 32'(sa / sb)};
          end
          3'd3: begin
            m_rem = 32;
            if (rt_val == 0) p_dz = 1'b1;
            else p_res = {rs_val % rt_val, rs_val / rt_val};
          end
          3'd4: m_hi = rs_val;
          3'd5: m_lo = rs_val;
          default: begin
`ifdef MULDIV_MADD_EN
            p_res = {m_hi, m_lo} + product(op, rs_val, rt_val);
            m_rem = 32;
`endif
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("busy",     64'(busy),     64'(m_rem != 0));
      chk("done",     64'(done),     64'(m_done));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      chk("hi",       64'(hi),       64'(m_hi));
      chk("lo",       64'(lo),       64'(m_lo));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (done === 1'b1) cnt++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      4:       return 32'h1;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int lat, cnt;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);

    issue(3'd0, 32'hFFFFFFFE, 32'h3);
    chk("mult_busy_e0", 64'(busy), 64'h1);
    wait_done(lat);
    chk("mult_latency", 64'(lat), 64'd32);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    chk("model_mult", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFA);

    issue(3'd1, 32'hFFFFFFFE, 32'h3);
    wait_done(lat);
    chk("multu_latency", 64'(lat), 64'd32);
    chk("multu_hilo", {hi, lo}, 64'h00000002_FFFFFFFA);
    chk("model_multu", {m_hi, m_lo}, 64'h00000002_FFFFFFFA);

    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    wait_done(lat);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("model_div", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    chk("div_ovf_dz", 64'(div_zero), 64'h0);

    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    chk("mthi_no_busy", 64'(busy), 64'h0);
    issue(3'd3, 32'h12345678, 32'h0);
    wait_done(lat);
    chk("divu0_latency", 64'(lat), 64'd32);
    chk("divu0_dz", 64'(div_zero), 64'h1);
    chk("divu0_hilo", {hi, lo}, 64'h00000011_00000022);

    // flush on cycle 10, with an ignored start while busy and a start dropped by the flush
    issue(3'd4, 32'h55, 32'h0);
    issue(3'd5, 32'h66, 32'h0);
    issue(3'd0, 32'h7, 32'h9);
    repeat (4) cyc();
    issue(3'd3, 32'h100, 32'h3);
    repeat (4) cyc();
    flush = 1'b1;
    issue(3'd0, 32'h5, 32'h5);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'h0);
    count_dones(40, cnt);
    chk("flush_no_done", 64'(cnt), 64'h0);
    chk("flush_hilo", {hi, lo}, 64'h00000055_00000066);

    issue(3'd1, 32'h10, 32'h20);
    repeat (3) cyc();
    issue(3'd2, 32'h9, 32'h2);
    wait_done(lat);
    chk("busy_start_latency", 64'(lat), 64'd28);
    count_dones(40, cnt);
    chk("busy_start_no_second_done", 64'(cnt), 64'h0);
    chk("busy_start_hilo", {hi, lo}, 64'h00000000_00000200);

    issue(3'd4, 32'hDEADBEEF, 32'h0);
    issue(3'd5, 32'h5, 32'h0);
    issue(3'd6, 32'h2, 32'h3);
`ifdef MULDIV_MADD_EN
    wait_done(lat);
    chk("madd_latency", 64'(lat), 64'd32);
    chk("madd_hilo", {hi, lo}, 64'hDEADBEEF_0000000B);
`else
    chk("madd_off_busy", 64'(busy), 64'h0);
    count_dones(4, cnt);
    chk("madd_off_no_done", 64'(cnt), 64'h0);
    chk("madd_off_hilo", {hi, lo}, 64'hDEADBEEF_00000005);
`endif

    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      op     = 3'($urandom_range(0, 7));
      rs_val = pick();
      rt_val = pick();
      flush  = ($urandom_range(0, 59) == 0);
      reset  = (i == 2000);
      cyc();
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (40) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
